// File: rtl/engine_cmd_rx_pkg.sv
// Graphics command package: receiver state encodings, bus byte width,
// per-engine packet lengths and engine indices (rts/rtr bit positions).
package engine_cmd_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } rx_state_t;

  localparam int BYTE_W = 8;

  // Parameter bytes carried by each engine's command packet
  localparam int TEST_PAT_BYTES  = 2;
  localparam int FILL_RECT_BYTES = 5;

  // Engine index == bit position in the broadcast rts/rtr vectors
  localparam int ENG_TEST_PAT  = 0;
  localparam int ENG_FILL_RECT = 1;
  localparam int ENG_COPY_RECT = 2;
  localparam int ENG_LINE      = 3;
  localparam int ENG_TEXT      = 4;

  function automatic int pkt_bits(input int num_bytes);
    return num_bytes * BYTE_W;
  endfunction

endpackage

// File: rtl/engine_cmd_rx.sv
// Engine-side command receiver: assembles NUM_BYTES broadcast bytes into one
// packet and holds it for the engine core. CMD_RX_CHECKSUM_EN adds an XOR check byte.
module engine_cmd_rx
  import engine_cmd_rx_pkg::*;
#(
  parameter int NUM_BYTES = FILL_RECT_BYTES
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          in_rts,
  output logic                          in_rtr,
  input  logic [BYTE_W-1:0]             in_data,
  input  logic                          flush,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output logic [pkt_bits(NUM_BYTES)-1:0] pkt_data,
  output logic                          busy,
  output logic                          err
);

  localparam int CNT_W = $clog2(NUM_BYTES + 2);

  rx_state_t          state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [BYTE_W-1:0]  slot_reg [NUM_BYTES];
  logic               xfer;

  // rtr depends only on the state register, never on rts or pkt_ready
  assign in_rtr    = (state_reg == S_COLLECT);
  assign pkt_valid = (state_reg == S_HOLD);
  assign busy      = (count_reg != '0) || (state_reg == S_HOLD);
  assign xfer      = in_rts && in_rtr;

`ifdef CMD_RX_CHECKSUM_EN
  localparam logic [CNT_W-1:0] CSUM_SLOT = CNT_W'(NUM_BYTES);

  logic [BYTE_W-1:0] csum_reg;
  logic              err_reg;

  assign err = err_reg;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      csum_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (flush) begin
        state_reg <= S_COLLECT;
        count_reg <= '0;
        csum_reg  <= '0;
      end else begin
        case (state_reg)
          S_IDLE: state_reg <= S_COLLECT;
          S_COLLECT: begin
            if (xfer) begin
              if (count_reg == CSUM_SLOT) begin
                // Check byte: good packet is held, bad one is dropped with an err pulse
                csum_reg <= '0;
                if (in_data == csum_reg) begin
                  state_reg <= S_HOLD;
                end else begin
                  err_reg   <= 1'b1;
                  count_reg <= '0;
                end
              end else begin
                csum_reg  <= csum_reg ^ in_data;
                count_reg <= count_reg + 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (pkt_ready) begin
              state_reg <= S_COLLECT;
              count_reg <= '0;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end
`else
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_BYTES - 1);

  assign err = 1'b0;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else if (flush) begin
      state_reg <= S_COLLECT;
      count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: state_reg <= S_COLLECT;
        S_COLLECT: begin
          if (xfer) begin
            count_reg <= count_reg + 1'b1;
            if (count_reg == LAST_DATA) begin
              state_reg <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (pkt_ready) begin
            state_reg <= S_COLLECT;
            count_reg <= '0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
`endif

  // Per-slot byte storage; slots are not cleared by flush, only by reset
  generate
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
      always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
          slot_reg[gi] <= '0;
        end else if (xfer && !flush && (count_reg == CNT_W'(gi))) begin
          slot_reg[gi] <= in_data;
        end
      end
      assign pkt_data[gi*BYTE_W +: BYTE_W] = slot_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_engine_cmd_rx.sv
// Self-checking bench for engine_cmd_rx: directed vector table, reset and
// checksum corner sequences, and a randomized-gap scoreboard run.
module tb_engine_cmd_rx;

  localparam int NB     = 5;
  localparam int DW     = NB * 8;
  localparam int N_RAND = 200;

  logic          clk = 1'b0;
  logic          rst_;
  logic          in_rts;
  logic          in_rtr;
  logic [7:0]    in_data;
  logic          flush;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [DW-1:0] pkt_data;
  logic          busy;
  logic          err;

  int n_vec  = 0;
  int n_miss = 0;

  engine_cmd_rx #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in_rts    (in_rts),
    .in_rtr    (in_rtr),
    .in_data   (in_data),
    .flush     (flush),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rts;
    logic [7:0]    data;
    logic          flush;
    logic          rdy;
    logic          e_rtr;
    logic          e_valid;
    logic          e_busy;
    logic          chk_data;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rts, input logic [7:0] data, input logic fl,
                     input logic rdy, input logic e_rtr, input logic e_valid,
                     input logic e_busy, input logic chk_data, input logic [DW-1:0] e_data);
    vec_t v;
    v.rts = rts; v.data = data; v.flush = fl; v.rdy = rdy;
    v.e_rtr = e_rtr; v.e_valid = e_valid; v.e_busy = e_busy;
    v.chk_data = chk_data; v.e_data = e_data;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rts, input logic [7:0] data, input logic fl, input logic rdy);
    in_rts    = rts;
    in_data   = data;
    flush     = fl;
    pkt_ready = rdy;
  endtask

  // Offer one byte per cycle, back to back
  task automatic send_bytes(input logic [7:0] b []);
    foreach (b[i]) begin
      drive(1'b1, b[i], 1'b0, 1'b0);
      #1 chk($sformatf("send_rtr[%0d]", i), 64'(in_rtr), 64'd1);
      @(negedge clk);
    end
  endtask

  logic [7:0]    stream[$];
  logic [DW-1:0] exp_pkts[$];

  initial begin
    logic [7:0]    csum;
    logic [DW-1:0] p;
    logic [7:0]    pkt_a [];
    int            si;
    int            ri;

    rst_ = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rtr",   64'(in_rtr),    64'd0);
    chk("rst_valid", 64'(pkt_valid), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_err",   64'(err),       64'd0);
    chk("rst_data",  64'(pkt_data),  64'd0);
    @(negedge clk);
    rst_ = 1'b1;

    // ---------------- vector table ----------------
    // Packet 1: byte offered in S_IDLE is ignored; held packet ignores rts
    add(1, 8'h99, 0, 0, 0, 0, 0, 0, '0);
    add(1, 8'h10, 0, 0, 1, 0, 0, 0, '0);
    add(1, 8'h20, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'h30, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'h40, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'hFF, 0, 0, 1, 0, 1, 0, '0);
`ifdef CMD_RX_CHECKSUM_EN
    add(1, 8'hBF, 0, 0, 1, 0, 1, 0, '0);
`endif
    add(1, 8'hAA, 0, 0, 0, 1, 1, 1, 40'hFF40302010);
    add(1, 8'hAA, 0, 0, 0, 1, 1, 1, 40'hFF40302010);
    add(1, 8'hAA, 0, 1, 0, 1, 1, 1, 40'hFF40302010);
    add(0, 8'h00, 0, 0, 1, 0, 0, 1, 40'hFF40302010);
    // Flush on a 4th byte: 0x55 discarded, slots keep partial bytes
    add(1, 8'hA1, 0, 0, 1, 0, 0, 0, '0);
    add(1, 8'hA2, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'hA3, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'h55, 1, 0, 1, 0, 1, 0, '0);
    add(0, 8'h00, 0, 0, 1, 0, 0, 1, 40'hFF40A3A2A1);
    add(1, 8'h01, 0, 0, 1, 0, 0, 0, '0);
    add(1, 8'h02, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'h03, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'h04, 0, 0, 1, 0, 1, 0, '0);
    add(1, 8'h05, 0, 0, 1, 0, 1, 0, '0);
`ifdef CMD_RX_CHECKSUM_EN
    add(1, 8'h01, 0, 0, 1, 0, 1, 0, '0);
`endif
    add(0, 8'h00, 0, 1, 0, 1, 1, 1, 40'h0504030201);
    add(0, 8'h00, 0, 0, 1, 0, 0, 1, 40'h0504030201);

    foreach (vecs[i]) begin
      drive(vecs[i].rts, vecs[i].data, vecs[i].flush, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_rtr", i),   64'(in_rtr),    64'(vecs[i].e_rtr));
      chk($sformatf("vec%0d_valid", i), 64'(pkt_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_busy", i),  64'(busy),      64'(vecs[i].e_busy));
      chk($sformatf("vec%0d_err", i),   64'(err),       64'd0);
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), 64'(pkt_data), 64'(vecs[i].e_data));
      @(negedge clk);
    end

    // ---------------- reset mid-packet ----------------
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hE2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_ = 1'b0;
    #1;
    chk("midrst_rtr",   64'(in_rtr),    64'd0);
    chk("midrst_busy",  64'(busy),      64'd0);
    chk("midrst_valid", 64'(pkt_valid), 64'd0);
    chk("midrst_data",  64'(pkt_data),  64'd0);
    @(negedge clk);
    rst_ = 1'b1;
    drive(1'b1, 8'hEE, 1'b0, 1'b0);
    #1 chk("postrst_idle_rtr", 64'(in_rtr), 64'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("postrst_rtr",  64'(in_rtr), 64'd1);
    chk("postrst_busy", 64'(busy),   64'd0);
`ifdef CMD_RX_CHECKSUM_EN
    pkt_a = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h61 ^ 8'h62 ^ 8'h63 ^ 8'h64 ^ 8'h65};
`else
    pkt_a = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
`endif
    send_bytes(pkt_a);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("postrst_valid", 64'(pkt_valid), 64'd1);
    chk("postrst_data",  64'(pkt_data),  64'h6564636261);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("postrst_hs_rtr",   64'(in_rtr),    64'd1);
    chk("postrst_hs_valid", 64'(pkt_valid), 64'd0);

`ifdef CMD_RX_CHECKSUM_EN
    // ---------------- bad checksum ----------------
    pkt_a = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 8'hBE};
    send_bytes(pkt_a);
    #1;
    chk("badcs_err",   64'(err),       64'd1);
    chk("badcs_valid", 64'(pkt_valid), 64'd0);
    chk("badcs_busy",  64'(busy),      64'd0);
    chk("badcs_rtr",   64'(in_rtr),    64'd1);
    @(negedge clk);
    #1;
    chk("badcs_err_off", 64'(err),       64'd0);
    chk("badcs_valid2",  64'(pkt_valid), 64'd0);
    pkt_a = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h71 ^ 8'h72 ^ 8'h73 ^ 8'h74 ^ 8'h75};
    send_bytes(pkt_a);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    #1;
    chk("aftbad_valid", 64'(pkt_valid), 64'd1);
    chk("aftbad_data",  64'(pkt_data),  64'h7574737271);
    chk("aftbad_err",   64'(err),       64'd0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    // ---------------- random gaps / backpressure scoreboard ----------------
    for (int k = 0; k < N_RAND; k++) begin
      csum = '0;
      for (int b = 0; b < NB; b++) begin
        p[b*8 +: 8] = 8'($urandom);
        stream.push_back(p[b*8 +: 8]);
        csum = csum ^ p[b*8 +: 8];
      end
`ifdef CMD_RX_CHECKSUM_EN
      stream.push_back(csum);
`endif
      exp_pkts.push_back(p);
    end
    si = 0;
    ri = 0;
    for (int cyc = 0; cyc < 20000 && ri < N_RAND; cyc++) begin
      in_rts    = (si < stream.size()) && ($urandom_range(0, 1) == 1);
      in_data   = in_rts ? stream[si] : 8'($urandom);
      pkt_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (in_rts && in_rtr) si++;
      if (pkt_valid && pkt_ready) begin
        chk($sformatf("rand_pkt%0d", ri), 64'(pkt_data), 64'(exp_pkts[ri]));
        ri++;
      end
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rand_pkts_received", 64'(ri), 64'(N_RAND));
    chk("rand_bytes_sent",    64'(si), 64'(stream.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/engine_cmd_rx.md
Name: engine_cmd_rx

Overview:
- Engine-side receiver for the command broadcast bus driven by the command processor.
- Accepts bytes on one engine's rts/rtr lane and assembles a fixed-length parameter packet, e.g. a fill-rect packet (x, y, w, h, color).
- Presents the packet to the engine core with a valid/ready handshake.
- Deasserts rtr while a packet is held, so the processor stalls.

Parameters:
- NUM_BYTES, 5, data bytes per packet; legal range 1..16.
- BYTE_W, 8, byte width; fixed to the broadcast bus width.

Ports:
- clk  in  1  clock
- rst_  in  1  asynchronous active-low reset
- in_rts  in  1  byte offered; driven by this engine's engine_out_rts bit
- in_rtr  out  1  byte can be accepted; feeds this engine's engine_in_rtr bit
- in_data  in  8  broadcast byte (bcast_out_data)
- flush  in  1  synchronous abort of any partial or held packet
- pkt_valid  out  1  assembled packet available
- pkt_ready  in  1  engine core consumes packet
- pkt_data  out  8*NUM_BYTES  assembled packet; byte 0 in bits [7:0]
- busy  out  1  partial packet in progress or packet held
- err  out  1  one-cycle checksum-error pulse

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_. All state is registered.
- Reset values: state S_IDLE, byte count 0, pkt_valid 0, pkt_data 0, err 0, in_rtr 0, busy 0.
- Transfer occurs when in_rts && in_rtr on a rising clk edge.
- in_rtr decodes from the state register only; there is no combinational path from in_rts or pkt_ready.

States:
- S_IDLE
  - in_rtr=0.
  - Lasts exactly one cycle after reset release, then goes to S_COLLECT.
- S_COLLECT
  - in_rtr=1.
  - On transfer, in_data is written to byte slot[count] and count increments.
  - The transfer of byte NUM_BYTES-1 moves to S_HOLD; pkt_valid=1 starting the next cycle.
- S_HOLD
  - in_rtr=0. pkt_valid=1. pkt_data stable.
  - On pkt_valid && pkt_ready: pkt_valid=0 next cycle, count=0, state returns to S_COLLECT.
  - in_rtr is 1 again on the cycle after the handshake.

Timing and widths:
- Latency from last byte accepted to pkt_valid high: 1 cycle.
- Peak throughput: NUM_BYTES+1 cycles per packet.
- Count width is $clog2(NUM_BYTES+2); count never exceeds the packet length.
- busy = (count != 0) || (state == S_HOLD).

Boundary conditions:
- flush has priority over a same-cycle transfer and a same-cycle pkt_ready.
  - Next cycle: count=0, pkt_valid=0, state S_COLLECT.
  - The byte offered in the flush cycle is discarded.
  - pkt_data is not cleared.
- in_rts high while in S_HOLD or S_IDLE: no transfer, no state change.
- in_rts gaps mid-packet: count holds indefinitely; there is no timeout.
- NUM_BYTES=1: every transfer moves directly to S_HOLD.
- Reset asserted mid-packet or mid-hold: all partial data and the held packet are lost. Outputs go to reset values immediately.

Optional Feature:
- Macro: CMD_RX_CHECKSUM_EN.
- When defined:
  - Each packet carries NUM_BYTES+1 bytes. The final byte is the XOR of all data bytes and is not stored in pkt_data.
  - The XOR accumulates on each data transfer and is compared on the checksum-byte transfer.
  - Match: go to S_HOLD as normal.
  - Mismatch: pkt_valid stays 0, err=1 for exactly one cycle, count=0, state stays S_COLLECT.
  - flush also clears the accumulator.
- When not defined:
  - Packet is NUM_BYTES bytes with no checksum logic.
  - err is tied to 0.

Decomposition:
- Shared package (graphics command package):
  - State encodings S_IDLE/S_COLLECT/S_HOLD.
  - BYTE_W=8.
  - Per-engine packet-length constants: TEST_PAT_BYTES, FILL_RECT_BYTES.
  - Engine index constants 0..4 matching the rts bit positions.
- No sub-module. The XOR accumulator is a few lines inline; splitting it out adds ports without reuse.

Test Plan:
- NUM_BYTES=5. Send 0x10,0x20,0x30,0x40,0xFF back-to-back with pkt_ready=0 → pkt_valid=1 one cycle after the 5th byte; pkt_data=40'hFF40302010; in_rtr=0 and held until pkt_ready.
- Extra in_rts held high during S_HOLD with in_data=0xAA, then pkt_ready pulse → no capture; pkt_data unchanged; in_rtr=1 the cycle after the handshake.
- Send 3 bytes, assert flush in the same cycle as a 4th byte 0x55, then send 5 fresh bytes 0x01..0x05 → packet = 40'h0504030201; busy=0 the cycle after flush.
- Send 2 bytes, assert rst_=0 mid-packet, release, wait for S_IDLE to pass, send 5 bytes → in_rtr=0 during reset and the first cycle after release; the packet contains only post-reset bytes.
- With CMD_RX_CHECKSUM_EN: send 0x10,0x20,0x30,0x40,0xFF plus checksum 0xBF → valid packet. Repeat with checksum 0xBE → err pulses exactly 1 cycle, pkt_valid stays 0, next packet is accepted normally.
- Random in_rts gaps (about 50%) and random pkt_ready over 200 packets → scoreboard matches every packet in order, with no dropped or duplicated bytes.
